// File: rtl/type_sequencer_pkg.sv
// Shared types for the typing-game sequencer: character ids, FSM states and
// the word table that backs the word ROM.
package typer_pkg;

   typedef logic [4:0] char_id_t;

   localparam char_id_t CH_A = 5'd0,  CH_B = 5'd1,  CH_C = 5'd2,  CH_D = 5'd3;
   localparam char_id_t CH_E = 5'd4,  CH_F = 5'd5,  CH_G = 5'd6,  CH_H = 5'd7;
   localparam char_id_t CH_I = 5'd8,  CH_J = 5'd9,  CH_K = 5'd10, CH_L = 5'd11;
   localparam char_id_t CH_M = 5'd12, CH_N = 5'd13, CH_O = 5'd14, CH_P = 5'd15;
   localparam char_id_t CH_Q = 5'd16, CH_R = 5'd17, CH_S = 5'd18, CH_T = 5'd19;
   localparam char_id_t CH_U = 5'd20, CH_V = 5'd21, CH_W = 5'd22, CH_X = 5'd23;
   localparam char_id_t CH_Y = 5'd24, CH_Z = 5'd25;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAW_REQ,
      ST_DRAW_WAIT,
      ST_TYPE_WAIT,
      ST_ERASE_REQ,
      ST_ERASE_WAIT
   } seq_state_t;

   localparam int CHAR_W_DEFAULT  = 8;
   localparam int MAX_LEN_DEFAULT = 8;
   localparam int ROM_SLOTS       = 8;
   localparam int ROM_LEN_W       = 4;

   // chars[0] is the leftmost letter; len may exceed ROM_SLOTS and is clamped by the sequencer.
   typedef struct packed {
      logic [ROM_LEN_W-1:0]       len;
      char_id_t [ROM_SLOTS-1:0]   chars;
   } word_entry_t;

   function automatic word_entry_t word_entry(input int id);
      word_entry_t e;
      e = '0;
      case (id)
         0: begin e.len = 4'd3;  e.chars = {25'd0, CH_T, CH_A, CH_C}; end
         1: begin e.len = 4'd0;  e.chars = '0; end
         2: begin e.len = 4'd8;  e.chars = {CH_D, CH_R, CH_A, CH_O, CH_B, CH_Y, CH_E, CH_K}; end
         3: begin e.len = 4'd3;  e.chars = {25'd0, CH_G, CH_O, CH_D}; end
         4: begin e.len = 4'd12; e.chars = {CH_W, CH_O, CH_L, CH_F, CH_R, CH_E, CH_V, CH_O}; end
         5: begin e.len = 4'd2;  e.chars = {30'd0, CH_O, CH_G}; end
         6: begin e.len = 4'd4;  e.chars = {20'd0, CH_E, CH_P, CH_Y, CH_T}; end
         7: begin e.len = 4'd1;  e.chars = {35'd0, CH_A}; end
         default: e = '0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/type_sequencer_word_rom.sv
// Word ROM: one entry per word id holding a length and up to ROM_SLOTS
// character ids, read through a single output register.
module word_rom
   import typer_pkg::*;
#(
   parameter int NUM_WORDS = 16,
   parameter int ID_W      = $clog2(NUM_WORDS),
   parameter int IDX_W     = 3
)(
   input  logic                 clk,
   input  logic [ID_W-1:0]      word_id,
   input  logic [IDX_W-1:0]     index,
   output char_id_t             char_id,
   output logic [ROM_LEN_W-1:0] len
);

   word_entry_t mem [NUM_WORDS];

   for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_mem
      assign mem[gi] = word_entry(gi);
   end

   always_ff @(posedge clk) begin
      char_id <= mem[word_id].chars[index];
      len     <= mem[word_id].len;
   end

endmodule

// File: rtl/type_sequencer.sv
// Typing-game control stage: loads a word, has the drawer paint it, then
// checks keystrokes and erases each correctly typed character.
module type_sequencer
   import typer_pkg::*;
#(
   parameter int MAX_LEN   = MAX_LEN_DEFAULT,
   parameter int CHAR_W    = CHAR_W_DEFAULT,
   parameter int NUM_WORDS = 16
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [$clog2(NUM_WORDS)-1:0]  word_id,
   input  logic                          key_valid,
   input  logic [4:0]                    key_code,
   output logic                          draw_go,
   output logic                          draw_delete,
   output logic [4:0]                    draw_char,
   output logic [6:0]                    draw_base_x,
   input  logic                          draw_done,
   output logic                          busy,
   output logic [$clog2(MAX_LEN)-1:0]    char_index,
   output logic                          mistake,
   output logic                          word_done
);

   localparam int ID_W  = $clog2(NUM_WORDS);
   localparam int IDX_W = $clog2(MAX_LEN);
   localparam int LEN_W = ROM_LEN_W;
   localparam int X_W   = 7;
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   if ((MAX_LEN - 1) * CHAR_W > 127) begin : g_bad_pitch
      $fatal(1, "type_sequencer: (MAX_LEN-1)*CHAR_W does not fit the 7-bit draw_base_x");
   end
   if (MAX_LEN < 2 || MAX_LEN > ROM_SLOTS) begin : g_bad_len
      $fatal(1, "type_sequencer: MAX_LEN must lie between 2 and the ROM slot count");
   end

   seq_state_t         state_reg;
   logic [ID_W-1:0]    word_reg;
   logic [IDX_W-1:0]   index_reg;
   logic [LEN_W-1:0]   len_reg;

   logic [ID_W-1:0]    word_sel;
   logic [IDX_W-1:0]   rom_index;
   char_id_t           rom_char;
   logic [LEN_W-1:0]   rom_len;
   logic [LEN_W-1:0]   len_clamped;
   logic               last_char;
   logic               req_done;

   assign char_index  = index_reg;
   assign last_char   = (LEN_W'(index_reg) + LEN_W'(1)) == len_reg;
   assign len_clamped = (rom_len > MAX_LEN_L) ? MAX_LEN_L : rom_len;
   assign req_done    = (state_reg == ST_DRAW_WAIT || state_reg == ST_ERASE_WAIT) && draw_done;

   // The ROM is addressed with the index the FSM will hold after this edge, so
   // rom_char always reflects index_reg and the REQ states need no extra cycle.
   always_comb begin
      word_sel  = (state_reg == ST_IDLE) ? word_id : word_reg;
      rom_index = index_reg;
      if (state_reg == ST_IDLE) begin
         rom_index = '0;
      end else if (req_done) begin
         rom_index = last_char ? '0 : index_reg + IDX_W'(1);
      end
   end

   word_rom #(
      .NUM_WORDS (NUM_WORDS),
      .ID_W      (ID_W),
      .IDX_W     (IDX_W)
   ) u_rom (
      .clk     (clk),
      .word_id (word_sel),
      .index   (rom_index),
      .char_id (rom_char),
      .len     (rom_len)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         word_reg    <= '0;
         index_reg   <= '0;
         len_reg     <= '0;
         draw_go     <= 1'b0;
         draw_delete <= 1'b0;
         draw_char   <= '0;
         draw_base_x <= '0;
         busy        <= 1'b0;
         mistake     <= 1'b0;
         word_done   <= 1'b0;
      end else begin
         mistake   <= 1'b0;
         word_done <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  word_reg  <= word_id;
                  index_reg <= '0;
                  busy      <= 1'b1;
                  state_reg <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               len_reg   <= len_clamped;
               index_reg <= '0;
               if (len_clamped == '0) begin
                  word_done <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  state_reg <= ST_DRAW_REQ;
               end
            end
            ST_DRAW_REQ: begin
               draw_go     <= 1'b1;
               draw_delete <= 1'b0;
               draw_char   <= rom_char;
               draw_base_x <= X_W'(index_reg * CHAR_W);
               state_reg   <= ST_DRAW_WAIT;
            end
            ST_DRAW_WAIT: begin
               if (draw_done) begin
                  draw_go <= 1'b0;
                  if (last_char) begin
                     index_reg <= '0;
                     state_reg <= ST_TYPE_WAIT;
                  end else begin
                     index_reg <= index_reg + IDX_W'(1);
                     state_reg <= ST_DRAW_REQ;
                  end
               end
            end
            ST_TYPE_WAIT: begin
               if (key_valid) begin
                  if (key_code == rom_char) begin
                     state_reg <= ST_ERASE_REQ;
                  end else begin
                     mistake <= 1'b1;
                  end
               end
            end
            ST_ERASE_REQ: begin
               draw_go     <= 1'b1;
               draw_delete <= 1'b1;
               draw_char   <= rom_char;
               draw_base_x <= X_W'(index_reg * CHAR_W);
               state_reg   <= ST_ERASE_WAIT;
            end
            ST_ERASE_WAIT: begin
               if (draw_done) begin
                  draw_go <= 1'b0;
                  if (last_char) begin
                     index_reg <= '0;
                     word_done <= 1'b1;
                     busy      <= 1'b0;
                     state_reg <= ST_IDLE;
                  end else begin
                     index_reg <= index_reg + IDX_W'(1);
                     state_reg <= ST_TYPE_WAIT;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_type_sequencer.sv
// Directed bench for type_sequencer: drawer model with fixed done latency and
// a scoreboard of expected draw/erase requests checked as each request rises.
module tb_type_sequencer;

   localparam int LAT    = 64;
   localparam int PITCH  = 8;
   localparam int MAXLEN = 8;

   typedef struct packed {
      logic       del;
      logic [4:0] ch;
      logic [6:0] x;
   } req_t;

   logic       clk = 1'b0;
   logic       reset, start, key_valid, draw_done;
   logic [3:0] word_id;
   logic [4:0] key_code;
   logic       draw_go, draw_delete, busy, mistake, word_done;
   logic [4:0] draw_char;
   logic [6:0] draw_base_x;
   logic [2:0] char_index;

   int   vectors = 0;
   int   miscompares = 0;
   req_t exp_q[$];
   req_t cur_req;
   req_t last_req;
   logic go_prev = 1'b0;
   int   lat_cnt;
   int   req_seen = 0;
   int   done_seen = 0;
   int   mistake_seen = 0;
   int   word_done_seen = 0;

   always #5 clk = ~clk;

   type_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .word_id     (word_id),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .draw_go     (draw_go),
      .draw_delete (draw_delete),
      .draw_char   (draw_char),
      .draw_base_x (draw_base_x),
      .draw_done   (draw_done),
      .busy        (busy),
      .char_index  (char_index),
      .mistake     (mistake),
      .word_done   (word_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic string tb_word(input int id);
      case (id)
         0: return "CAT";
         2: return "KEYBOARD";
         4: return "OVERFLOWTEST";
         default: return "";
      endcase
   endfunction

   function automatic int tb_len(input int id);
      string s = tb_word(id);
      return (s.len() > MAXLEN) ? MAXLEN : s.len();
   endfunction

   function automatic logic [4:0] tb_code(input int id, input int i);
      string s = tb_word(id);
      return 5'(s[i] - 8'h41);
   endfunction

   // Drawer: done rises LAT cycles after go, and is cleared once go drops.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         draw_done <= 1'b0;
         lat_cnt   <= 0;
      end else if (!draw_go) begin
         draw_done <= 1'b0;
         lat_cnt   <= 0;
      end else if (!draw_done) begin
         if (lat_cnt == LAT - 1) draw_done <= 1'b1;
         lat_cnt <= lat_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (draw_go && !go_prev) begin
         req_seen++;
         cur_req = {draw_delete, draw_char, draw_base_x};
         last_req = cur_req;
         check("req_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check("req_fields", 32'(cur_req), 32'(exp_q.pop_front()));
      end
      if (draw_go && draw_done) begin
         done_seen++;
         check("req_stable", 32'({draw_delete, draw_char, draw_base_x}), 32'(cur_req));
      end
      if (mistake) mistake_seen++;
      if (word_done) word_done_seen++;
      go_prev = draw_go;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] outs();
      return {draw_go, draw_delete, draw_char, draw_base_x, busy, char_index, mistake, word_done};
   endfunction

   task automatic push_word(input int id);
      for (int i = 0; i < tb_len(id); i++)
         exp_q.push_back({1'b0, tb_code(id, i), 7'(i * PITCH)});
   endtask

   task automatic start_word(input int id);
      word_id = 4'(id);
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_done(input int target, input string tag);
      for (int c = 0; c < 4000 && done_seen < target; c++) tick();
      check(tag, 32'(done_seen >= target), 32'd1);
      tick();
   endtask

   task automatic press(input logic [4:0] code, input bit match, input int idx);
      if (match) exp_q.push_back({1'b1, code, 7'(idx * PITCH)});
      key_valid = 1'b1;
      key_code  = code;
      tick();
      key_valid = 1'b0;
      if (match) begin
         check("erase_req_gap", 32'(draw_go), 32'd0);
         check("no_mistake_on_match", 32'(mistake), 32'd0);
         tick();
         check("key_latency", 32'(draw_go), 32'd1);
      end else begin
         check("mistake_pulse", 32'(mistake), 32'd1);
         check("mistake_index_kept", 32'(char_index), 32'(idx));
         tick();
         check("mistake_width", 32'(mistake), 32'd0);
      end
   endtask

   task automatic type_word(input int id);
      int n = tb_len(id);
      for (int i = 0; i < n; i++) begin
         int base = done_seen;
         check("type_index", 32'(char_index), 32'(i));
         press(tb_code(id, i), 1'b1, i);
         if (i < n - 1) begin
            wait_done(base + 1, "erase_timeout");
         end else begin
            for (int c = 0; c < LAT + 20 && word_done !== 1'b1; c++) tick();
            check("word_done_pulse", 32'(word_done), 32'd1);
            check("busy_falls_with_done", 32'(busy), 32'd0);
            tick();
            check("word_done_width", 32'(word_done), 32'd0);
         end
      end
   endtask

   initial begin
      int base;
      int reqs;
      reset = 1'b1; start = 1'b0; word_id = '0; key_valid = 1'b0; key_code = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'(outs()), 32'd0);
      reset = 1'b0;
      tick(); tick();
      check("idle_after_reset", 32'({busy, draw_go}), 32'd0);

      // Reset while a paint request is outstanding.
      exp_q.push_back({1'b0, tb_code(0, 0), 7'd0});
      start_word(0);
      repeat (10) tick();
      check("in_draw_wait", 32'(draw_go), 32'd1);
      #2 reset = 1'b1;
      #1 check("async_reset_outputs", 32'(outs()), 32'd0);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      check("idle_after_mid_reset", 32'({busy, draw_go, word_done}), 32'd0);
      check("queue_after_reset", 32'(exp_q.size()), 32'd0);

      // Paint CAT, with a stray key and an overlapping start during drawing.
      base = done_seen;
      reqs = req_seen;
      push_word(0);
      start_word(0);
      check("fetch_busy", 32'(busy), 32'd1);
      check("fetch_no_go", 32'(draw_go), 32'd0);
      tick();
      check("draw_req_no_go", 32'(draw_go), 32'd0);
      tick();
      check("start_latency", 32'(draw_go), 32'd1);
      key_valid = 1'b1; key_code = tb_code(0, 0);
      tick();
      key_valid = 1'b0;
      check("key_ignored_in_draw", 32'(mistake), 32'd0);
      start_word(2);
      check("start_ignored_busy", 32'(busy), 32'd1);
      wait_done(base + 3, "draw_timeout");
      check("draws_issued", 32'(req_seen - reqs), 32'd3);
      check("type_wait_index", 32'(char_index), 32'd0);
      check("type_wait_state", 32'({busy, draw_go}), 32'b10);

      // Typing: one wrong key, then the word.
      press(5'd5, 1'b0, 0);
      type_word(0);

      // Zero-length entry.
      reqs = req_seen;
      start_word(1);
      check("zero_len_busy", 32'(busy), 32'd1);
      tick();
      check("zero_len_done", 32'(word_done), 32'd1);
      check("zero_len_idle", 32'(busy), 32'd0);
      tick();
      check("zero_len_width", 32'(word_done), 32'd0);
      repeat (3) tick();
      check("zero_len_no_draw", 32'(req_seen - reqs), 32'd0);

      // Full 8-character word; last cell at x=56.
      base = done_seen;
      push_word(2);
      start_word(2);
      wait_done(base + 8, "long_draw_timeout");
      check("last_cell_x", 32'(last_req.x), 32'd56);
      type_word(2);

      // Over-long ROM length clamped to 8 characters.
      base = done_seen;
      reqs = req_seen;
      push_word(4);
      start_word(4);
      wait_done(base + 8, "clamp_draw_timeout");
      repeat (LAT + 4) tick();
      check("clamp_draw_count", 32'(req_seen - reqs), 32'd8);
      type_word(4);

      repeat (4) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("word_done_total", 32'(word_done_seen), 32'd4);
      check("mistake_total", 32'(mistake_seen), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
